// File: rtl/rom_arb_pkg.sv
// Shared definitions for the ROM read arbiter: FSM state encoding and
// default bus widths.
package rom_arb_pkg;
  localparam int ROM_ADDR_W = 2;
  localparam int ROM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rom_read_arbiter_if.sv
// Requester-side bus of the ROM read arbiter: two request/grant channels
// and a shared response data bus with per-requester valid/ready.
interface rom_read_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
);
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              gnt0, gnt1;
  logic              rsp_valid0, rsp_valid1;
  logic              rsp_ready0, rsp_ready1;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req0, req1, addr0, addr1, rsp_ready0, rsp_ready1,
    input  gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data
  );

  modport slave (
    input  req0, req1, addr0, addr1, rsp_ready0, rsp_ready1,
    output gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data
  );
endinterface

// File: rtl/rom_read_arbiter_arb2.sv
// Two-way arbiter: request vector in, one-hot winner out.
// ROM_ARB_RR_EN defined: round-robin on ties, pointer tracks the last winner.
// ROM_ARB_RR_EN undefined: fixed priority, requester 0 wins ties.
module arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] win
);
`ifdef ROM_ARB_RR_EN
  logic last;

  // On a tie favour the requester that did not win last time
  always_comb begin
    win = req;
    if (req == 2'b11) win = last ? 2'b01 : 2'b10;
  end

  // Remember the winner of every grant; reset value lets requester 0 go first
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   last <= 1'b1;
    else if (adv) last <= win[1];
`else
  logic unused_ok;
  assign win       = {req[1] & ~req[0], req[0]};
  assign unused_ok = &{1'b0, clk, rst_n, adv};
`endif
endmodule

// File: rtl/rom_read_arbiter.sv
// Arbitrates two requesters onto one combinational ROM. One transaction at
// a time: IDLE (grant + address capture) -> READ (data capture) -> RESP
// (hold until the owner accepts). Tie policy set by ROM_ARB_RR_EN (see arb2).
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  rom_read_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              busy
);
  arb_state_e        st, nxt;
  logic [1:0]        win, gnt, vld;
  logic              owner, owner_rdy;
  logic              grant, load, done;
  logic [DATA_W-1:0] data;

  arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({bus.req1, bus.req0}),
    .adv   (grant),
    .win   (win)
  );

  // Only the owner's ready can close a response
  assign owner_rdy = owner ? bus.rsp_ready1 : bus.rsp_ready0;

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else        st <= nxt;

  // Next-state and per-phase strobes
  always_comb begin
    nxt   = st;
    grant = 1'b0;
    load  = 1'b0;
    done  = 1'b0;
    case (st)
      IDLE: if (bus.req0 | bus.req1) begin grant = 1'b1; nxt = READ; end
      READ: begin load = 1'b1; nxt = RESP; end
      RESP: if (owner_rdy) begin done = 1'b1; nxt = IDLE; end
      default: nxt = IDLE;
    endcase
  end

  // Datapath: grant pulse, address/owner capture, response data and valid
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gnt      <= '0;
      vld      <= '0;
      owner    <= 1'b0;
      rom_addr <= '0;
      data     <= '0;
    end else begin
      gnt <= grant ? win : 2'b00;
      if (grant) begin
        rom_addr <= win[1] ? bus.addr1 : bus.addr0;
        owner    <= win[1];
      end
      if (load) begin
        data <= rom_dout;
        vld  <= owner ? 2'b10 : 2'b01;
      end
      if (done) vld <= 2'b00;
    end

  assign bus.gnt0       = gnt[0];
  assign bus.gnt1       = gnt[1];
  assign bus.rsp_valid0 = vld[0];
  assign bus.rsp_valid1 = vld[1];
  assign bus.rsp_data   = data;
  assign busy           = (st != IDLE);
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: directed vector table, corner-case sequences
// and a randomized run against a transaction-level reference model.
module tb_rom_read_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] rom_addr;
  logic [7:0] rom_dout;
  logic       busy;
  int         n_vec = 0;
  int         n_err = 0;

  rom_read_arbiter_if #(.ADDR_W(2), .DATA_W(8)) bus ();

  rom_read_arbiter #(.ADDR_W(2), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // ROM contents: 0xA0 + address
  assign rom_dout = 8'hA0 + {6'b0, rom_addr};

  // Output bundle {gnt1,gnt0,valid1,valid0,busy,rom_addr,rsp_data}
  logic [14:0] dut_o;
  assign dut_o = {bus.gnt1, bus.gnt0, bus.rsp_valid1, bus.rsp_valid0, busy,
                  rom_addr, bus.rsp_data};

  function automatic logic [14:0] mk(logic g1, logic g0, logic v1, logic v0,
                                     logic b, logic [1:0] ra, logic [7:0] d);
    return {g1, g0, v1, v0, b, ra, d};
  endfunction

  task automatic chk(string name, logic [14:0] act, logic [14:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit       m_busy, m_waiting, m_owner, m_last;
  bit [1:0] m_addr, m_gnt, m_vld;
  bit [7:0] m_data;

  function automatic void m_reset();
    m_busy = 0; m_waiting = 0; m_owner = 0; m_last = 1;
    m_addr = 0; m_gnt = 0; m_vld = 0; m_data = 0;
  endfunction

  // Advance the model by one clock using the inputs currently on the bus
  function automatic void m_tick();
    bit w;
    bit [1:0] g = 2'b00;
    if (!m_busy) begin
      if (bus.req0 || bus.req1) begin
        if (bus.req0 && bus.req1)
`ifdef ROM_ARB_RR_EN
          w = ~m_last;
`else
          w = 0;
`endif
        else w = bus.req1;
        m_owner = w; m_last = w;
        m_addr = w ? bus.addr1 : bus.addr0;
        g[w] = 1'b1;
        m_busy = 1; m_waiting = 0;
      end
    end else if (!m_waiting) begin
      m_data = 8'hA0 + {6'b0, m_addr};
      m_vld[m_owner] = 1'b1;
      m_waiting = 1;
    end else if (m_owner ? bus.rsp_ready1 : bus.rsp_ready0) begin
      m_vld = 0; m_busy = 0; m_waiting = 0;
    end
    m_gnt = g;
  endfunction

  function automatic logic [14:0] m_out();
    return mk(m_gnt[1], m_gnt[0], m_vld[1], m_vld[0], m_busy, m_addr, m_data);
  endfunction

  task automatic step(string name);
    m_tick();
    @(posedge clk); #1;
    chk(name, dut_o, m_out());
  endtask

  task automatic drive(bit r0, bit r1, bit [1:0] a0, bit [1:0] a1, bit rd0, bit rd1);
    bus.req0 = r0; bus.req1 = r1; bus.addr0 = a0; bus.addr1 = a1;
    bus.rsp_ready0 = rd0; bus.rsp_ready1 = rd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    m_reset();
    #1 chk("reset_state", dut_o, 15'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic        r0, r1;
    logic [1:0]  a0, a1;
    logic        rd0, rd1;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // Directed table: single read by 0 with held-off ready, then by 1 with
    // the non-owner's ready asserted, then idle.
    tbl[0] = '{1, 0, 2'd2, 2'd0, 0, 0, mk(0, 1, 0, 0, 1, 2'd2, 8'h00)};
    tbl[1] = '{0, 0, 2'd2, 2'd0, 0, 0, mk(0, 0, 0, 1, 1, 2'd2, 8'hA2)};
    tbl[2] = '{0, 0, 2'd2, 2'd0, 0, 0, mk(0, 0, 0, 1, 1, 2'd2, 8'hA2)};
    tbl[3] = '{0, 0, 2'd2, 2'd0, 1, 0, mk(0, 0, 0, 0, 0, 2'd2, 8'hA2)};
    tbl[4] = '{0, 1, 2'd0, 2'd3, 1, 0, mk(1, 0, 0, 0, 1, 2'd3, 8'hA2)};
    tbl[5] = '{0, 0, 2'd0, 2'd3, 1, 0, mk(0, 0, 1, 0, 1, 2'd3, 8'hA3)};
    tbl[6] = '{0, 0, 2'd0, 2'd3, 1, 0, mk(0, 0, 1, 0, 1, 2'd3, 8'hA3)};
    tbl[7] = '{0, 0, 2'd0, 2'd3, 0, 1, mk(0, 0, 0, 0, 0, 2'd3, 8'hA3)};
    tbl[8] = '{0, 0, 2'd0, 2'd0, 0, 0, mk(0, 0, 0, 0, 0, 2'd3, 8'hA3)};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].r0, tbl[i].r1, tbl[i].a0, tbl[i].a1, tbl[i].rd0, tbl[i].rd1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), dut_o, tbl[i].exp);
    end

    // Simultaneous requests, both held, ready always high
    do_reset();
    drive(1, 1, 2'd0, 2'd3, 1, 1);
    for (int i = 0; i < 7; i++) begin
      step("tie");
      if (i == 3)
`ifdef ROM_ARB_RR_EN
        chk("tie_second_winner", dut_o, mk(1, 0, 0, 0, 1, 2'd3, 8'hA0));
`else
        chk("tie_second_winner", dut_o, mk(0, 1, 0, 0, 1, 2'd0, 8'hA0));
`endif
    end

    // Owner stalls ready for 5 cycles while requester 1 waits
    do_reset();
    drive(1, 0, 2'd1, 2'd0, 0, 0);
    step("stall_gnt");
    drive(0, 1, 2'd1, 2'd2, 0, 1);
    step("stall_read");
    for (int i = 0; i < 5; i++) step("stall_hold");
    chk("stall_data", dut_o, mk(0, 0, 0, 1, 1, 2'd1, 8'hA1));
    bus.rsp_ready0 = 1'b1;
    step("stall_accept");
    bus.rsp_ready0 = 1'b0;
    step("stall_gnt1");
    bus.req1 = 1'b0;
    for (int i = 0; i < 3; i++) step("stall_tail");

    // Reset pulse in the middle of a read
    do_reset();
    drive(1, 0, 2'd1, 2'd0, 1, 1);
    step("rst_gnt");
    bus.req0 = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("rst_async", dut_o, 15'd0);
    m_reset();
    #2 rst_n = 1'b1;
    step("rst_after0");
    step("rst_after1");
    drive(1, 0, 2'd3, 2'd0, 1, 1);
    step("rst_regrant");
    bus.req0 = 1'b0;
    step("rst_read");

    // Request raised and withdrawn inside one idle cycle
    do_reset();
    drive(0, 0, 0, 0, 1, 1);
    step("wd_idle");
    bus.req1 = 1'b1; bus.addr1 = 2'd1;
    #3 bus.req1 = 1'b0;
    step("wd_nogrant");
    step("wd_still_idle");

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom), 2'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
